mem_stage: RTL and testbench



---
 rtl/pipeline_pkg.sv | 28 ++
 rtl/mem_align.sv | 41 ++++
 rtl/mem_stage.sv | 150 +++++++++++++++
 tb/tb_mem_stage.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared encodings for the pipeline: access size/sign, writeback select, MEM FSM state.
package pipeline_pkg;

  localparam logic [2:0] DM_WORD   = 3'd0;
  localparam logic [2:0] DM_HALF   = 3'd1;
  localparam logic [2:0] DM_HALF_U = 3'd2;
  localparam logic [2:0] DM_BYTE   = 3'd3;
  localparam logic [2:0] DM_BYTE_U = 3'd4;

  localparam logic [1:0] WDSEL_ALU = 2'd0;
  localparam logic [1:0] WDSEL_MEM = 2'd1;
  localparam logic [1:0] WDSEL_PC4 = 2'd2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_t;

  // Unknown size encodings are treated as word accesses.
  function automatic logic is_aligned(input logic [2:0] dm_type, input logic [1:0] addr_lo);
    case (dm_type)
      DM_HALF, DM_HALF_U: is_aligned = (addr_lo[0] == 1'b0);
      DM_BYTE, DM_BYTE_U: is_aligned = 1'b1;
      default:            is_aligned = (addr_lo == 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/mem_align.sv
// Store lane replication / byte enables and load lane extract with sign or zero extension.
module mem_align
  import pipeline_pkg::*;
(
  input  logic [2:0]  dm_type,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] load_data
);

  logic [31:0] byte_shift;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign byte_shift = rdata >> {addr_lo, 3'b000};
  assign ld_byte    = byte_shift[7:0];
  assign ld_half    = addr_lo[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    wdata     = store_data;
    be        = 4'b1111;
    load_data = rdata;
    case (dm_type)
      DM_HALF, DM_HALF_U: begin
        wdata     = {2{store_data[15:0]}};
        be        = addr_lo[1] ? 4'b1100 : 4'b0011;
        load_data = (dm_type == DM_HALF) ? {{16{ld_half[15]}}, ld_half} : {16'h0000, ld_half};
      end
      DM_BYTE, DM_BYTE_U: begin
        wdata     = {4{store_data[7:0]}};
        be        = 4'b0001 << addr_lo;
        load_data = (dm_type == DM_BYTE) ? {{24{ld_byte[7]}}, ld_byte} : {24'h000000, ld_byte};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: data-memory req/ack handshake with ack timeout, stall generation
// and the MEM/WB register.
//   state   | meaning
//   ST_IDLE | no access outstanding; a new aligned mem op issues its request here
//   ST_WAIT | request held high, waiting for dmem_ack or the timeout limit
module mem_stage
  import pipeline_pkg::*;
#(
  parameter int ACK_TIMEOUT = 255,
  parameter int TO_W        = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PC_in,
  input  logic [4:0]  rd_in,
  input  logic [31:0] alures_in,
  input  logic [31:0] rs2_data_in,
  input  logic [31:0] imm_in,
  input  logic        MemWrite_in,
  input  logic [2:0]  DMType_in,
  input  logic        RegWrite_in,
  input  logic [1:0]  WDSel_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        stall_mem,
  output logic [31:0] PC_out,
  output logic [4:0]  rd_out,
  output logic [31:0] alures_out,
  output logic [31:0] imm_out,
  output logic [31:0] mdata_out,
  output logic        RegWrite_out,
  output logic [1:0]  WDSel_out,
  output logic        misalign_out,
  output logic        bus_err_out
);

  localparam logic [TO_W-1:0] TO_LIM = TO_W'(ACK_TIMEOUT);
  localparam logic [TO_W-1:0] TO_ONE = TO_W'(1);

  mem_state_t      state, state_nxt;
  logic [TO_W-1:0] cnt, cnt_nxt;
  logic            is_load, mem_op, aligned, misalign, timeout_hit;
  logic            req_raw, stall_raw;
  logic [31:0]     wdata_al, load_data;
  logic [3:0]      be_al;

  assign is_load     = (WDSel_in == WDSEL_MEM);
  assign mem_op      = MemWrite_in | is_load;
  assign aligned     = is_aligned(DMType_in, alures_in[1:0]);
  assign misalign    = mem_op & ~aligned;
  assign timeout_hit = (state == ST_WAIT) & ~dmem_ack & (cnt == TO_LIM);

  mem_align u_align (
    .dm_type    (DMType_in),
    .addr_lo    (alures_in[1:0]),
    .store_data (rs2_data_in),
    .rdata      (dmem_rdata),
    .wdata      (wdata_al),
    .be         (be_al),
    .load_data  (load_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    req_raw   = 1'b0;
    stall_raw = 1'b0;
    case (state)
      ST_IDLE: begin
        if (mem_op && aligned) begin
          req_raw = 1'b1;
          if (!dmem_ack) begin
            stall_raw = 1'b1;
            state_nxt = ST_WAIT;
            cnt_nxt   = TO_ONE;
          end
        end
      end
      ST_WAIT: begin
        req_raw = 1'b1;
        if (dmem_ack || timeout_hit) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else begin
          stall_raw = 1'b1;
          cnt_nxt   = cnt + TO_ONE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Bus strobes are forced low while reset is held, even though inputs may still show a mem op.
  assign dmem_req   = rst & req_raw;
  assign dmem_we    = dmem_req & MemWrite_in;
  assign dmem_be    = dmem_we ? be_al : 4'b0000;
  assign dmem_addr  = {alures_in[31:2], 2'b00};
  assign dmem_wdata = wdata_al;
  assign stall_mem  = rst & stall_raw;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      PC_out       <= '0;
      rd_out       <= '0;
      alures_out   <= '0;
      imm_out      <= '0;
      mdata_out    <= '0;
      RegWrite_out <= 1'b0;
      WDSel_out    <= '0;
      misalign_out <= 1'b0;
      bus_err_out  <= 1'b0;
    end else if (stall_mem) begin
      PC_out       <= '0;
      rd_out       <= '0;
      alures_out   <= '0;
      imm_out      <= '0;
      mdata_out    <= '0;
      RegWrite_out <= 1'b0;
      WDSel_out    <= '0;
      misalign_out <= 1'b0;
      bus_err_out  <= 1'b0;
    end else begin
      PC_out       <= PC_in;
      rd_out       <= rd_in;
      alures_out   <= alures_in;
      imm_out      <= imm_in;
      mdata_out    <= (is_load && !misalign && !timeout_hit) ? load_data : 32'h0;
      RegWrite_out <= RegWrite_in & ~misalign & ~timeout_hit;
      WDSel_out    <= WDSel_in;
      misalign_out <= misalign;
      bus_err_out  <= timeout_hit;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: loads/stores, wait states, misalignment, timeout, async reset.
module tb_mem_stage;
  import pipeline_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] PC_in, alures_in, rs2_data_in, imm_in, dmem_rdata;
  logic [4:0]  rd_in;
  logic        MemWrite_in, RegWrite_in, dmem_ack;
  logic [2:0]  DMType_in;
  logic [1:0]  WDSel_in;
  logic        dmem_req, dmem_we, stall_mem;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic [31:0] PC_out, alures_out, imm_out, mdata_out;
  logic [4:0]  rd_out;
  logic        RegWrite_out, misalign_out, bus_err_out;
  logic [1:0]  WDSel_out;

  int n_total = 0;
  int n_bad   = 0;
  int scnt;

  always #5 clk = ~clk;

  mem_stage #(.ACK_TIMEOUT(4), .TO_W(16)) dut (
    .clk(clk), .rst(rst),
    .PC_in(PC_in), .rd_in(rd_in), .alures_in(alures_in), .rs2_data_in(rs2_data_in),
    .imm_in(imm_in), .MemWrite_in(MemWrite_in), .DMType_in(DMType_in),
    .RegWrite_in(RegWrite_in), .WDSel_in(WDSel_in),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .stall_mem(stall_mem),
    .PC_out(PC_out), .rd_out(rd_out), .alures_out(alures_out), .imm_out(imm_out),
    .mdata_out(mdata_out), .RegWrite_out(RegWrite_out), .WDSel_out(WDSel_out),
    .misalign_out(misalign_out), .bus_err_out(bus_err_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] addr,
                       input logic [31:0] rs2, input logic [31:0] imm, input logic we,
                       input logic [2:0] dmt, input logic rw, input logic [1:0] wds);
    PC_in = pc; rd_in = rd; alures_in = addr; rs2_data_in = rs2; imm_in = imm;
    MemWrite_in = we; DMType_in = dmt; RegWrite_in = rw; WDSel_in = wds;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_load_wait(input string tag, input logic [2:0] dmt, input logic [31:0] exp);
    issue(32'h1100, 5'd6, 32'h103, 32'h0, 32'h0, 1'b0, dmt, 1'b1, WDSEL_MEM);
    dmem_ack = 1'b0;
    scnt = 0;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) begin
        dmem_ack = 1'b1;
        dmem_rdata = 32'h80123456;
      end
      #1;
      if (stall_mem) scnt++;
      if (c < 2) chk({tag, "_req"}, 32'(dmem_req), 32'd1);
      tick();
      if (c < 2) chk({tag, "_bubble_rw"}, 32'(RegWrite_out), 32'd0);
    end
    chk({tag, "_stalls"}, 32'(scnt), 32'd2);
    chk({tag, "_mdata"}, mdata_out, exp);
    chk({tag, "_rw"}, 32'(RegWrite_out), 32'd1);
    chk({tag, "_rd"}, 32'(rd_out), 32'd6);
    dmem_ack = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    dmem_ack = 1'b0;
    dmem_rdata = 32'h0;
    issue(32'h0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, DM_WORD, 1'b0, WDSEL_ALU);
    #2;
    chk("rst_pc", PC_out, 32'h0);
    chk("rst_rw", 32'(RegWrite_out), 32'd0);
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_stall", 32'(stall_mem), 32'd0);
    @(posedge clk);
    #2 rst = 1'b1;
    tick();

    // LW, zero-wait ack
    issue(32'h1000, 5'd5, 32'h100, 32'h0, 32'h0, 1'b0, DM_WORD, 1'b1, WDSEL_MEM);
    dmem_ack = 1'b1; dmem_rdata = 32'hDEADBEEF;
    #1;
    chk("lw_stall", 32'(stall_mem), 32'd0);
    chk("lw_req", 32'(dmem_req), 32'd1);
    chk("lw_we", 32'(dmem_we), 32'd0);
    chk("lw_be", 32'(dmem_be), 32'd0);
    chk("lw_addr", dmem_addr, 32'h100);
    tick();
    chk("lw_mdata", mdata_out, 32'hDEADBEEF);
    chk("lw_rw", 32'(RegWrite_out), 32'd1);
    chk("lw_rd", 32'(rd_out), 32'd5);
    chk("lw_pc", PC_out, 32'h1000);
    dmem_ack = 1'b0;

    // byte loads with two wait cycles
    run_load_wait("lb", DM_BYTE, 32'hFFFFFF80);
    run_load_wait("lbu", DM_BYTE_U, 32'h00000080);

    // LH upper half, sign-extended
    issue(32'h1200, 5'd8, 32'h102, 32'h0, 32'h0, 1'b0, DM_HALF, 1'b1, WDSEL_MEM);
    dmem_ack = 1'b1; dmem_rdata = 32'h80123456;
    tick();
    chk("lh_mdata", mdata_out, 32'hFFFF8012);

    // stores
    issue(32'h1300, 5'd0, 32'h202, 32'h1234ABCD, 32'h0, 1'b1, DM_HALF, 1'b0, WDSEL_ALU);
    #1;
    chk("sh_we", 32'(dmem_we), 32'd1);
    chk("sh_be", 32'(dmem_be), 32'hC);
    chk("sh_wdata", dmem_wdata, 32'hABCDABCD);
    chk("sh_addr", dmem_addr, 32'h200);
    chk("sh_stall", 32'(stall_mem), 32'd0);
    tick();
    chk("sh_mdata", mdata_out, 32'h0);
    issue(32'h1304, 5'd0, 32'h101, 32'h000000EF, 32'h0, 1'b1, DM_BYTE, 1'b0, WDSEL_ALU);
    #1;
    chk("sb_be", 32'(dmem_be), 32'h2);
    chk("sb_wdata", dmem_wdata, 32'hEFEFEFEF);
    tick();
    issue(32'h1308, 5'd0, 32'h204, 32'hCAFEF00D, 32'h0, 1'b1, DM_WORD, 1'b0, WDSEL_ALU);
    #1;
    chk("sw_be", 32'(dmem_be), 32'hF);
    chk("sw_wdata", dmem_wdata, 32'hCAFEF00D);
    tick();

    // misaligned LW
    dmem_ack = 1'b0;
    issue(32'h1400, 5'd4, 32'h101, 32'h0, 32'h0, 1'b0, DM_WORD, 1'b1, WDSEL_MEM);
    #1;
    chk("mis_req", 32'(dmem_req), 32'd0);
    chk("mis_stall", 32'(stall_mem), 32'd0);
    tick();
    chk("mis_flag", 32'(misalign_out), 32'd1);
    chk("mis_rw", 32'(RegWrite_out), 32'd0);

    // ack timeout (limit 4)
    issue(32'h1500, 5'd7, 32'h300, 32'h0, 32'h0, 1'b0, DM_WORD, 1'b1, WDSEL_MEM);
    scnt = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (!stall_mem) break;
      scnt++;
      tick();
    end
    chk("to_stalls", 32'(scnt), 32'd4);
    chk("to_req_last", 32'(dmem_req), 32'd1);
    tick();
    chk("to_buserr", 32'(bus_err_out), 32'd1);
    chk("to_rw", 32'(RegWrite_out), 32'd0);
    chk("to_mdata", mdata_out, 32'h0);

    // late ack with an ALU op: ignored, op passes through
    issue(32'h2000, 5'd9, 32'h55, 32'h0, 32'h77, 1'b0, DM_WORD, 1'b1, WDSEL_ALU);
    dmem_ack = 1'b1;
    #1;
    chk("alu_stall", 32'(stall_mem), 32'd0);
    chk("alu_req", 32'(dmem_req), 32'd0);
    tick();
    chk("alu_res", alures_out, 32'h55);
    chk("alu_imm", imm_out, 32'h77);
    chk("alu_rd", 32'(rd_out), 32'd9);
    chk("alu_rw", 32'(RegWrite_out), 32'd1);
    chk("alu_buserr", 32'(bus_err_out), 32'd0);
    chk("alu_mdata", mdata_out, 32'h0);

    // async reset mid-WAIT
    dmem_ack = 1'b0;
    issue(32'h3000, 5'd3, 32'h400, 32'h0, 32'h0, 1'b0, DM_WORD, 1'b1, WDSEL_MEM);
    tick();
    tick();
    #2 rst = 1'b0;
    #1;
    chk("arst_req", 32'(dmem_req), 32'd0);
    chk("arst_stall", 32'(stall_mem), 32'd0);
    chk("arst_pc", PC_out, 32'h0);
    chk("arst_alures", alures_out, 32'h0);
    #2 rst = 1'b1;
    #1;
    chk("rel_req", 32'(dmem_req), 32'd1);
    chk("rel_stall", 32'(stall_mem), 32'd1);
    tick();
    dmem_ack = 1'b1; dmem_rdata = 32'h11223344;
    #1;
    chk("rel_ack_stall", 32'(stall_mem), 32'd0);
    tick();
    chk("rel_mdata", mdata_out, 32'h11223344);
    chk("rel_rw", 32'(RegWrite_out), 32'd1);
    chk("rel_rd", 32'(rd_out), 32'd3);
    dmem_ack = 1'b0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
